// File: rtl/store_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor_pkg
// Description : Shared types and default constants for the store monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package store_monitor_pkg;

    localparam logic [31:0] c_pass_addr   = 32'd100;
    localparam logic [31:0] c_pass_data   = 32'd25;
    localparam logic [31:0] c_ignore_addr = 32'd96;

    typedef enum logic [1:0] {
        CHK_RUN  = 2'd0,
        CHK_PASS = 2'd1,
        CHK_FAIL = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_fifo
// Description : Store-entry FIFO with explicit occupancy count; a pop frees a
//               slot for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module store_fifo
    import store_monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  store_entry_t             i_entry,
    output store_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    store_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full_cnt);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    // Gate the head so stale or unreset storage never leaks out while empty
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor
// Description : Captures committed stores into a drainable FIFO and runs an
//               end-of-program pass/fail checker on the store stream.
// Revision    : 1.0 - initial release
// ============================================================================
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] PASS_ADDR   = c_pass_addr,
    parameter logic [31:0] PASS_DATA   = c_pass_data,
    parameter logic [31:0] IGNORE_ADDR = c_ignore_addr,
    parameter int          CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     done,
    output logic                     pass
);

    store_entry_t     w_in;
    store_entry_t     w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;
    chk_state_t       r_state;
    chk_state_t       w_state_next;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    assign w_in.addr = DataAdr;
    assign w_in.data = WriteData;

    store_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (MemWrite),
        .i_pop   (out_ready),
        .i_entry (w_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign out_valid = ~w_empty;
    assign out_addr  = w_head.addr;
    assign out_data  = w_head.data;
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so only a stalled full FIFO drops
    assign w_drop    = MemWrite & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CHK_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Verdict is terminal; the ignore address keeps the run alive
    always_comb begin
        w_state_next = r_state;
        done         = (r_state != CHK_RUN);
        pass         = (r_state == CHK_PASS);
        if (MemWrite && (r_state == CHK_RUN)) begin
            if ((DataAdr == PASS_ADDR) && (WriteData == PASS_DATA)) begin
                w_state_next = CHK_PASS;
            end else if (DataAdr != IGNORE_ADDR) begin
                w_state_next = CHK_FAIL;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_monitor
// Description : Scoreboard bench for store_monitor: a reference FIFO/checker
//               model is stepped every cycle and compared against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_monitor;
    import store_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        done;
    logic        pass;

    int n_pass  = 0;
    int n_total = 0;

    store_entry_t sb[$];
    int           m_drop  = 0;
    int           m_ovf   = 0;
    int           m_state = 0;

    store_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .done       (done),
        .pass       (pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    always @(posedge reset) begin
        sb.delete();
        m_drop  = 0;
        m_ovf   = 0;
        m_state = 0;
    end

    // Compare mid-cycle, then advance the model to the upcoming rising edge
    always @(negedge clk) begin
        if (!reset) begin
            int  n;
            bit  pop;
            store_entry_t e;
            n = sb.size();
            chk("count", fifo_count, n);
            chk("valid", out_valid, n != 0);
            chk("drop_count", drop_count, m_drop);
            chk("overflow", overflow, m_ovf);
            chk("done", done, m_state != 0);
            chk("pass", pass, m_state == 1);
            pop = (n != 0) && out_ready;
            if (pop) begin
                e = sb.pop_front();
                chk("head_addr", out_addr, e.addr);
                chk("head_data", out_data, e.data);
            end
            if (MemWrite) begin
                if (n < 8 || pop) begin
                    e.addr = DataAdr;
                    e.data = WriteData;
                    sb.push_back(e);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                if (m_state == 0) begin
                    if (DataAdr == 32'd100 && WriteData == 32'd25) m_state = 1;
                    else if (DataAdr != 32'd96) m_state = 2;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        MemWrite = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_done", done, 1'b0);

        // Reset asserted between edges while entries are queued
        out_ready = 1'b0;
        store(32'h10, 32'd1);
        store(32'h14, 32'd2);
        store(32'h18, 32'd3);
        chk("pre_rst_count", fifo_count, 4'd3);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_count", fifo_count, 4'd0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        #1 reset = 1'b0;
        step();

        // Nominal pass with ignored stores first
        out_ready = 1'b1;
        store(32'd96, 32'd7);
        store(32'd96, 32'd9);
        store(32'd100, 32'd25);
        chk("nom_done", done, 1'b1);
        chk("nom_pass", pass, 1'b1);
        idle(4);
        chk("nom_drained", fifo_count, 4'd0);

        // Stray address fails; a later pass store cannot change the verdict
        pulse_reset();
        store(32'd104, 32'd25);
        chk("stray_done", done, 1'b1);
        chk("stray_pass", pass, 1'b0);
        store(32'd100, 32'd25);
        chk("stray_sticky", pass, 1'b0);
        idle(3);

        // Right address, wrong data
        pulse_reset();
        store(32'd100, 32'd24);
        chk("wdata_done", done, 1'b1);
        chk("wdata_pass", pass, 1'b0);
        idle(2);

        // Overflow then full with simultaneous push/pop
        pulse_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) store(32'd96, i);
        chk("ovf_count", fifo_count, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_count, 8'd2);
        chk("ovf_head", out_data, 32'd1);
        idle(2);
        chk("stall_head", out_data, 32'd1);
        out_ready = 1'b1;
        for (int i = 11; i <= 14; i++) store(32'd96, i);
        chk("pp_count", fifo_count, 4'd8);
        chk("pp_drops", drop_count, 8'd2);
        chk("pp_head", out_data, 32'd5);
        idle(10);
        chk("pp_drained", fifo_count, 4'd0);
        out_ready = 1'b0;
        idle(1);

        // Drop counter saturation
        pulse_reset();
        for (int i = 0; i < 8 + 260; i++) store(32'd96, i);
        chk("sat_drops", drop_count, 8'hff);
        chk("sat_count", fifo_count, 4'd8);
        out_ready = 1'b1;
        idle(10);
        chk("sat_drained", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable store-side monitor sitting directly downstream of the processor's data-memory write port (MemWrite, DataAdr, WriteData).
- Captures every committed store into a small FIFO for draining by a debug/trace consumer over a valid/ready handshake.
- Runs an on-chip pass/fail checker, so the end-of-program store check runs in hardware as well as in simulation.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- PASS_ADDR, 32'd100: store address that signals success.
- PASS_DATA, 32'd25: data value required at PASS_ADDR for success.
- IGNORE_ADDR, 32'd96: store address tolerated during the run without a verdict.
- CNT_W, 8: width of drop_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  processor store strobe, one store per cycle while high.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- out_valid  out  1  FIFO head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- fifo_count  out  $clog2(DEPTH)+1  current number of occupied entries.
- overflow  out  1  sticky flag; a store was dropped.
- drop_count  out  CNT_W  number of dropped stores; saturates at all-ones.
- done  out  1  checker has reached a verdict.
- pass  out  1  verdict is success; valid only while done=1.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - FIFO is emptied: out_valid=0, fifo_count=0, out_addr=0, out_data=0.
  - overflow=0, drop_count=0, done=0, pass=0, checker in CHK_RUN.
- Push: push = MemWrite, sampled on the rising edge.
- Pop: pop = out_valid & out_ready.
- Push accept rule: accepted iff fifo_count<DEPTH, or pop is true in the same cycle.
- Full with simultaneous push and pop: both take effect; fifo_count stays DEPTH; order is preserved.
- Empty with push: no bypass. The entry appears on out_valid/out_addr/out_data the cycle after the capturing edge (1-cycle latency).
- Empty with out_ready=1: no effect.
- Dropped store (push while full and no pop): entry discarded, overflow set to 1, drop_count incremented. drop_count saturates and never wraps.
- Pointers: read/write pointers have $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is tracked explicitly, so full and empty are unambiguous.
- out_addr/out_data hold the head entry while out_valid=1 and out_ready=0; the head must not change while stalled.
- Checker FSM, evaluated on every edge with MemWrite=1:
  - CHK_RUN -> CHK_PASS if DataAdr==PASS_ADDR and WriteData==PASS_DATA.
  - CHK_RUN -> CHK_FAIL if DataAdr!=IGNORE_ADDR and the pass condition does not hold. This includes PASS_ADDR with wrong data.
  - CHK_RUN stays in CHK_RUN if DataAdr==IGNORE_ADDR, or if MemWrite=0.
  - CHK_PASS and CHK_FAIL are terminal; only reset leaves them.
- Checker outputs: done = (state!=CHK_RUN); pass = (state==CHK_PASS). Both are registered and update on the same edge as the deciding store.
- After a verdict, FIFO capture continues unchanged.
- Checker and FIFO are independent: a dropped store is still checked.

Decomposition:
- Package store_monitor_pkg holds:
  - typedef enum chk_state_t {CHK_RUN, CHK_PASS, CHK_FAIL};
  - default constants for PASS_ADDR, PASS_DATA, IGNORE_ADDR;
  - typedef struct store_entry_t {addr[31:0], data[31:0]}.
- One sub-module, store_fifo: parameterized DEPTH, push/pop/full/empty/count over store_entry_t.
- Checker FSM and overflow/drop counters live in store_monitor.

Test Plan:
- Reset mid-operation: 3 stores queued, then reset pulsed asynchronously between edges -> out_valid=0, fifo_count=0, done=0, overflow=0 immediately.
- Nominal pass: stores (96,7), (96,9), (100,25), out_ready=1 -> done=1, pass=1 after the third edge; entries drain in order (96,7), (96,9), (100,25).
- Fail on stray address: store (104,25) -> done=1, pass=0 after that edge; a later (100,25) leaves the verdict unchanged.
- Fail on wrong data: store (100,24) -> done=1, pass=0.
- Overflow: DEPTH=8, out_ready=0, 10 consecutive stores of data 1..10 -> fifo_count=8, overflow=1, drop_count=2; draining yields data 1..8 only.
- Full with simultaneous push/pop: FIFO full, MemWrite=1 and out_ready=1 for 4 cycles -> fifo_count stays 8, drop_count unchanged, and the 4 new entries appear after the original 8.
